// File: rtl/mux4_arbiter_if.sv
// Bus between the four requesters and the shared 4:1 mux arbiter.
//   req     : per-requester request, held high for the whole transfer
//   gnt     : registered one-hot grant, zero when nobody owns the path
//   sel     : registered mux select, index of the current or last owner
//   valid   : high exactly while gnt is non-zero
//   preempt : one-cycle pulse in the dead cycle after a forced release
// master = requester side, slave = arbiter side.
interface mux4_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       preempt;

  modport master (output req, input gnt, input sel, input valid, input preempt);
  modport slave  (input req, output gnt, output sel, output valid, output preempt);
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 single-bit mux path.
// Grants one requester at a time and holds the grant until that requester
// releases. It inserts one dead cycle between owners, and it preempts an
// owner that holds the path for MAX_HOLD cycles while others wait.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux4_arbiter_if (req in; gnt/sel/valid/preempt out)
// Parameter:
//   MAX_HOLD : max BUSY cycles per contended grant, 0 disables preemption
module mux4_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux4_arbiter_if.slave  bus
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic PREEMPT_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic               valid_q;
  logic               preempt_q;
  logic [SEL_W-1:0]   last_q;
  logic [CNT_W-1:0]   hold_q;

  logic               win_found_c;
  logic [SEL_W-1:0]   win_idx_c;
  logic [SEL_W-1:0]   cand_c;
  logic               owner_req_c;
  logic               others_c;
  logic               hold_full_c;

  // Round-robin search: last+1, last+2, last+3, then last itself.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = last_q;
    cand_c      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = last_q + SEL_W'(k);
      if (!win_found_c && bus.req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // Owner status. In BUSY gnt_q is the one-hot of sel_q, so masking with it
  // leaves only the competing requests.
  assign owner_req_c = bus.req[sel_q];
  assign others_c    = |(bus.req & ~gnt_q);
  assign hold_full_c = (hold_q == HOLD_LAST);

  // Arbitration FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      last_q    <= SEL_W'(N_REQ - 1);
      hold_q    <= '0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (win_found_c) begin
            state_q <= ST_BUSY;
            gnt_q   <= N_REQ'(1) << win_idx_c;
            sel_q   <= win_idx_c;
            last_q  <= win_idx_c;
            valid_q <= 1'b1;
            hold_q  <= '0;
          end else begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (!owner_req_c) begin
            // A normal release takes priority over a coincident preemption.
            state_q <= ST_GAP;
            gnt_q   <= '0;
            valid_q <= 1'b0;
          end else if (PREEMPT_EN && hold_full_c && others_c) begin
            state_q   <= ST_GAP;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b1;
          end else if (!hold_full_c) begin
            hold_q <= hold_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.valid   = valid_q;
  assign bus.preempt = preempt_q;

  // Structural invariants of the registered outputs.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));
  a_valid_match : assert property (@(posedge clk) disable iff (!rst_n)
    valid_q == (|gnt_q));
  a_preempt_gap : assert property (@(posedge clk) disable iff (!rst_n)
    preempt_q |-> (state_q == ST_GAP));

endmodule

// File: tb/tb_mux4_arbiter.sv
// Self-checking bench for mux4_arbiter: directed vector table, hand-written
// multi-cycle corner sequences, and randomized traffic against a
// requester-level reference model.
module tb_mux4_arbiter;

  localparam int unsigned MH = 8;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  mux4_arbiter_if bus ();

  mux4_arbiter #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the path, who owned it last, how long it has held.
  int m_owner;
  int m_last;
  int m_sel;
  int m_hold;
  bit m_pre;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_hold  = 0;
    m_pre   = 1'b0;
  endtask

  // Apply the rules for one clock edge with request vector r.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    if (m_owner >= 0) begin
      others = r & ~(4'(1) << m_owner);
      if (!r[m_owner]) begin
        m_owner = -1;
        m_pre   = 1'b0;
      end else if (MH != 0 && m_hold == int'(MH) - 1 && others != 4'b0) begin
        m_owner = -1;
        m_pre   = 1'b1;
      end else begin
        if (m_hold < int'(MH) - 1) m_hold++;
        m_pre = 1'b0;
      end
    end else begin
      m_pre = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_last  = idx;
          m_sel   = idx;
          m_hold  = 0;
        end
      end
    end
  endtask

  task automatic cmp(input string nm, input string fld,
                     input logic [3:0] act, input logic [3:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %b, expected %b", nm, fld, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic ep);
    cmp(nm, "gnt", bus.gnt, eg);
    cmp(nm, "sel", 4'(bus.sel), 4'(es));
    cmp(nm, "valid", 4'(bus.valid), 4'(ev));
    cmp(nm, "preempt", 4'(bus.preempt), 4'(ep));
  endtask

  task automatic check_model(input string nm);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1) << m_owner : 4'b0;
    check(nm, eg, 2'(m_sel), m_owner >= 0, m_pre);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 4'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       pre;
  } vec_t;

  vec_t vt [16];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0;
    model_reset();

    // Single grant and release, then round-robin handover with 2-cycle holds.
    vt[0]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 4'b1101, 4'b0000, 2'd1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[10] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[11] = '{1'b0, 4'b1011, 4'b0000, 2'd2, 1'b0, 1'b0};
    vt[12] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[13] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[14] = '{1'b0, 4'b0111, 4'b0000, 2'd3, 1'b0, 1'b0};
    vt[15] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};

    do_reset();
    check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      if (vt[i].rst) do_reset();
      bus.req = vt[i].req;
      step();
      check($sformatf("vec%0d", i), vt[i].gnt, vt[i].sel, vt[i].valid, vt[i].pre);
    end

    // Contended hold limit: req[2] held, req[0] joins during the third cycle.
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 2) bus.req = 4'b0101;
      check($sformatf("hold%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step();
    check("preempt_gap", 4'b0000, 2'd2, 1'b0, 1'b1);
    step();
    check("preempt_next", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Uncontended ownership is never preempted.
    do_reset();
    bus.req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("solo%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end

    // Release on the same edge the hold limit is reached: plain release.
    do_reset();
    bus.req = 4'b0101;
    for (int c = 0; c < 8; c++) step();
    check("sim_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req = 4'b0100;
    step();
    check("sim_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    check("sim_next", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Asynchronous reset while requester 3 owns the path.
    do_reset();
    bus.req = 4'b1000;
    step();
    check("pre_rst", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.req = 4'b1001;
    step();
    check("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Randomized traffic: owners keep their request longer than bystanders.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] r;
      r = bus.req;
      for (int b = 0; b < 4; b++) begin
        if (b == m_owner) begin
          if ($urandom_range(15) == 0) r[b] = ~r[b];
        end else if ($urandom_range(3) == 0) begin
          r[b] = ~r[b];
        end
      end
      bus.req = r;
      model_step(r);
      step();
      check_model($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
